regbank_writeback: RTL and testbench
====================================

Name: regbank_writeback

Overview:
Write-side front end for the 20-entry register bank; it is the only block that drives the bank's write port.
- Accepts writeback requests from two producers (ALU result path, memory-load path) over valid/ready handshakes.
- Buffers requests in a small FIFO and drains one per cycle onto the bank's pw/write_addr/write_data, all registered on posedge. The bank captures them on the following negedge.
- Reports per-register "write pending" status so operand fetch can stall on hazards.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
NREGS, 20, number of implemented registers; writes to addr >= NREGS are discarded
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle
alu_addr  input  AW  ALU destination register
alu_data  input  DW  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load request accepted this cycle
mem_addr  input  AW  load destination register
mem_data  input  DW  load data
hold  input  1  freeze draining (bank write port blocked)
pw  output  1  write permission to bank (registered)
write_addr  output  AW  bank write address (registered)
write_data  output  DW  bank write data (registered)
chk_addr1  input  AW  operand 1 address to check
chk_addr2  input  AW  operand 2 address to check
busy1  output  1  write to chk_addr1 pending
busy2  output  1  write to chk_addr2 pending
count  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - FIFO empties; count=0.
  - pw=0, write_addr=0, write_data=0.
  - busy1=busy2=0.
  - Pending writes are lost.
  - Outputs hold these values until the first posedge after reset deasserts.
- Arbitration:
  - mem_ready = (count<DEPTH).
  - alu_ready = (count<DEPTH) && !mem_valid.
  - At most one push per cycle; load beats ALU.
  - A transfer occurs when valid&&ready at posedge.
  - Ready depends only on registered count, never on same-cycle pop (no full-FIFO pass-through).
- Discard: an accepted request with addr==0 or addr>=NREGS is consumed (ready honoured) but not enqueued. count is unchanged by it.
- Drain, at each posedge:
  - If hold=0 and count>0 (pre-edge value): pw<=1, write_addr/write_data <= head entry, head popped.
  - Otherwise pw<=0; write_addr/write_data hold their previous values.
- Occupancy: push and pop in the same edge leave count unchanged; order is strictly FIFO.
- Latency: a request accepted at edge N into an empty FIFO appears with pw=1 after edge N+1 and is written by the bank at the negedge within that cycle.
- Ordering: same-register writes reach the bank in acceptance order, so the last accepted value wins.
- Busy (combinational):
  - busyK=1 iff chk_addrK!=0 and it matches any valid FIFO entry, or matches write_addr while pw=1.
  - Entries being accepted in the current cycle are not included.
- Hold: with hold=1, pw=0 and FIFO contents are frozen; pushes still accepted until full.

Test Plan:
- Reset then alu_valid=1, alu_addr=3, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1; next cycle pw=1, write_addr=3, write_data=0xDEADBEEF for exactly one cycle; count returns to 0; busy on chk_addr1=3 high for the cycle pw=1.
- alu_valid and mem_valid both high (alu r5=1, mem r6=2) -> mem accepted first, alu_ready=0 that cycle; bank sees r6=2 then r5=1 on consecutive pw cycles.
- hold=1, push 4 writes (r1..r4=0x11..0x44) -> count=4, mem_ready=alu_ready=0 on 5th attempt. Release hold -> pw high 4 consecutive cycles in order r1..r4.
- Push addr 0 and addr 25 -> both accepted, count stays 0, pw never asserted, busy1 with chk_addr1=0 stays 0.
- Push r7=0xA then r7=0xB with hold=1 -> busy1(chk_addr1=7)=1 until both drained; bank ends with r7=0xB.
- Assert reset=0 mid-drain with count=3 -> pw=0, write_addr=0, write_data=0, count=0 immediately (asynchronous); no further bank writes after release.

Source files
------------

// File: rtl/regbank_writeback_if.sv
// Purpose: bundles the producer handshakes, bank write port and hazard-check
//          signals of regbank_writeback into one interface.
// Latency: none (wires only).
// Backpressure: carried by alu_ready / mem_ready and the hold input.
// Ports / modports:
//   slave  - the writeback block: takes requests, hold and check addresses;
//            drives readies, pw/write_addr/write_data, busy1/2 and count.
//   master - the environment: producers, bank and operand-fetch side.
interface regbank_writeback_if #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          hold;
    logic          pw;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] chk_addr1;
    logic [AW-1:0] chk_addr2;
    logic          busy1;
    logic          busy2;
    logic [CW-1:0] count;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  hold, chk_addr1, chk_addr2,
        output alu_ready, mem_ready,
        output pw, write_addr, write_data,
        output busy1, busy2, count
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output hold, chk_addr1, chk_addr2,
        input  alu_ready, mem_ready,
        input  pw, write_addr, write_data,
        input  busy1, busy2, count
    );
endinterface

// File: rtl/regbank_writeback.sv
// Purpose: sole writer of the register bank; arbitrates ALU/load writebacks into a FIFO and drains one per cycle.
// Latency: request accepted at edge N (empty FIFO) drives pw/write_addr/write_data after edge N+1.
// Backpressure: readies drop when the FIFO is full (registered count only); hold freezes draining, not accepting.
// Ports:
//   clk   - system clock, all state on posedge
//   reset - asynchronous active-low reset
//   bus   - regbank_writeback_if.slave: producer handshakes, hold, bank write
//           port (pw/write_addr/write_data), hazard checks (chk/busy), count
module regbank_writeback #(
    parameter int DEPTH = 4,
    parameter int NREGS = 20,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    regbank_writeback_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_pw;
    logic [AW-1:0] r_write_addr;
    logic [DW-1:0] r_write_data;

    logic          w_mem_rdy;
    logic          w_alu_rdy;
    logic          w_take;
    logic [AW-1:0] w_push_addr;
    logic [DW-1:0] w_push_data;
    logic          w_in_range;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_off;
    logic          w_hit1;
    logic          w_hit2;

    // Readies look only at the registered count so a full FIFO never
    // accepts on the strength of a same-cycle pop.
    assign w_mem_rdy = (r_count < CW'(DEPTH));
    assign w_alu_rdy = w_mem_rdy && !bus.mem_valid;

    // Load path has priority whenever it is requesting.
    assign w_push_addr = bus.mem_valid ? bus.mem_addr : bus.alu_addr;
    assign w_push_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
    assign w_take      = (bus.mem_valid && w_mem_rdy) || (bus.alu_valid && w_alu_rdy);

    // r0 and unimplemented registers are swallowed: handshake completes,
    // nothing is stored.
    assign w_in_range = (w_push_addr != '0) && ({1'b0, w_push_addr} < NREGS_W);
    assign w_push     = w_take && w_in_range;
    assign w_pop      = !bus.hold && (r_count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_pw         <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            if (w_pop) begin
                r_pw         <= 1'b1;
                r_write_addr <= r_fifo_addr[r_rptr];
                r_write_data <= r_fifo_data[r_rptr];
                r_rptr       <= r_rptr + 1'b1;
            end else begin
                r_pw <= 1'b0;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= w_push_addr;
            r_fifo_data[r_wptr] <= w_push_data;
        end
    end

    // An entry is live when its distance from the read pointer is below
    // count; the register currently on the bank port counts as pending too.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rptr;
            if ({1'b0, w_off} < r_count) begin
                if (r_fifo_addr[i] == bus.chk_addr1) w_hit1 = 1'b1;
                if (r_fifo_addr[i] == bus.chk_addr2) w_hit2 = 1'b1;
            end
        end
        if (r_pw && (r_write_addr == bus.chk_addr1)) w_hit1 = 1'b1;
        if (r_pw && (r_write_addr == bus.chk_addr2)) w_hit2 = 1'b1;
    end

    assign bus.mem_ready  = w_mem_rdy;
    assign bus.alu_ready  = w_alu_rdy;
    assign bus.pw         = r_pw;
    assign bus.write_addr = r_write_addr;
    assign bus.write_data = r_write_data;
    assign bus.count      = r_count;
    assign bus.busy1      = w_hit1 && (bus.chk_addr1 != '0);
    assign bus.busy2      = w_hit2 && (bus.chk_addr2 != '0);
endmodule

// File: tb/tb_regbank_writeback.sv
// Purpose: directed self-checking bench for regbank_writeback with a negedge bank model.
// Latency: inputs driven 1ns after posedge; registered outputs sampled there, combinational ones 1ns after driving.
// Backpressure: exercised by full-FIFO attempts under hold and by simultaneous producers.
module tb_regbank_writeback;
    logic clk;
    logic reset;

    regbank_writeback_if #(.AW(5), .DW(32), .CW(3)) u_if ();

    regbank_writeback #(
        .DEPTH(4),
        .NREGS(20),
        .AW(5),
        .DW(32)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_cnt  = 0;
    logic [31:0] bank [32];

    // Bank captures the write port on the negedge inside the pw cycle.
    always @(negedge clk) begin
        if (u_if.pw === 1'b1) begin
            bank[u_if.write_addr] = u_if.write_data;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.alu_valid = 1'b0;
        u_if.alu_addr  = '0;
        u_if.alu_data  = '0;
        u_if.mem_valid = 1'b0;
        u_if.mem_addr  = '0;
        u_if.mem_data  = '0;
    endtask

    task automatic push_alu(input logic [4:0] a, input logic [31:0] d);
        u_if.alu_valid = 1'b1;
        u_if.alu_addr  = a;
        u_if.alu_data  = d;
        step();
        idle_inputs();
    endtask

    int snap;

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
        reset = 1'b0;
        idle_inputs();
        u_if.hold      = 1'b0;
        u_if.chk_addr1 = '0;
        u_if.chk_addr2 = '0;
        #1;
        check("rst_count", 32'(u_if.count), 32'd0);
        check("rst_pw", 32'(u_if.pw), 32'd0);
        check("rst_waddr", 32'(u_if.write_addr), 32'd0);
        check("rst_wdata", u_if.write_data, 32'd0);
        check("rst_busy1", 32'(u_if.busy1), 32'd0);
        check("rst_busy2", 32'(u_if.busy2), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Single ALU write, latency and busy window.
        u_if.chk_addr1 = 5'd3;
        u_if.alu_valid = 1'b1;
        u_if.alu_addr  = 5'd3;
        u_if.alu_data  = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", 32'(u_if.alu_ready), 32'd1);
        check("t1_busy_pre", 32'(u_if.busy1), 32'd0);
        step();
        idle_inputs();
        check("t1_count1", 32'(u_if.count), 32'd1);
        check("t1_pw_early", 32'(u_if.pw), 32'd0);
        check("t1_busy_fifo", 32'(u_if.busy1), 32'd1);
        step();
        check("t1_pw", 32'(u_if.pw), 32'd1);
        check("t1_waddr", 32'(u_if.write_addr), 32'd3);
        check("t1_wdata", u_if.write_data, 32'hDEADBEEF);
        check("t1_count0", 32'(u_if.count), 32'd0);
        check("t1_busy_pw", 32'(u_if.busy1), 32'd1);
        step();
        check("t1_pw_off", 32'(u_if.pw), 32'd0);
        check("t1_busy_off", 32'(u_if.busy1), 32'd0);
        check("t1_waddr_hold", 32'(u_if.write_addr), 32'd3);
        check("t1_bank3", bank[3], 32'hDEADBEEF);

        // Simultaneous producers: load wins.
        u_if.alu_valid = 1'b1; u_if.alu_addr = 5'd5; u_if.alu_data = 32'd1;
        u_if.mem_valid = 1'b1; u_if.mem_addr = 5'd6; u_if.mem_data = 32'd2;
        #1;
        check("t2_mem_ready", 32'(u_if.mem_ready), 32'd1);
        check("t2_alu_blocked", 32'(u_if.alu_ready), 32'd0);
        step();
        u_if.mem_valid = 1'b0;
        #1;
        check("t2_alu_ready", 32'(u_if.alu_ready), 32'd1);
        step();
        idle_inputs();
        check("t2_pw_a", 32'(u_if.pw), 32'd1);
        check("t2_waddr_a", 32'(u_if.write_addr), 32'd6);
        check("t2_wdata_a", u_if.write_data, 32'd2);
        check("t2_count_a", 32'(u_if.count), 32'd1);
        step();
        check("t2_pw_b", 32'(u_if.pw), 32'd1);
        check("t2_waddr_b", 32'(u_if.write_addr), 32'd5);
        check("t2_wdata_b", u_if.write_data, 32'd1);
        step();
        check("t2_pw_off", 32'(u_if.pw), 32'd0);

        // Fill under hold, reject on full, then drain in order.
        u_if.hold = 1'b1;
        for (int i = 1; i <= 4; i++) push_alu(5'(i), 32'(i * 32'h11));
        check("t3_count_full", 32'(u_if.count), 32'd4);
        check("t3_pw_held", 32'(u_if.pw), 32'd0);
        u_if.alu_valid = 1'b1; u_if.alu_addr = 5'd9;  u_if.alu_data = 32'h99;
        u_if.mem_valid = 1'b1; u_if.mem_addr = 5'd10; u_if.mem_data = 32'hAA;
        #1;
        check("t3_mem_ready_full", 32'(u_if.mem_ready), 32'd0);
        check("t3_alu_ready_full", 32'(u_if.alu_ready), 32'd0);
        step();
        idle_inputs();
        check("t3_count_still", 32'(u_if.count), 32'd4);
        u_if.hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t3_pw_%0d", i), 32'(u_if.pw), 32'd1);
            check($sformatf("t3_waddr_%0d", i), 32'(u_if.write_addr), 32'(i));
            check($sformatf("t3_wdata_%0d", i), u_if.write_data, 32'(i * 32'h11));
            check($sformatf("t3_count_%0d", i), 32'(u_if.count), 32'(4 - i));
        end
        step();
        check("t3_pw_off", 32'(u_if.pw), 32'd0);
        check("t3_bank9", bank[9], 32'd0);

        // Discarded addresses.
        snap = wr_cnt;
        u_if.chk_addr1 = 5'd0;
        u_if.alu_valid = 1'b1; u_if.alu_addr = 5'd0; u_if.alu_data = 32'h55;
        #1;
        check("t4_ready_r0", 32'(u_if.alu_ready), 32'd1);
        step();
        idle_inputs();
        u_if.mem_valid = 1'b1; u_if.mem_addr = 5'd25; u_if.mem_data = 32'h66;
        #1;
        check("t4_ready_r25", 32'(u_if.mem_ready), 32'd1);
        step();
        idle_inputs();
        check("t4_count", 32'(u_if.count), 32'd0);
        check("t4_busy1", 32'(u_if.busy1), 32'd0);
        step();
        step();
        check("t4_pw", 32'(u_if.pw), 32'd0);
        check("t4_no_writes", 32'(wr_cnt - snap), 32'd0);

        // Same-register writes: busy until both drained, last wins.
        u_if.chk_addr1 = 5'd7;
        u_if.hold = 1'b1;
        push_alu(5'd7, 32'hA);
        push_alu(5'd7, 32'hB);
        check("t5_count", 32'(u_if.count), 32'd2);
        check("t5_busy_held", 32'(u_if.busy1), 32'd1);
        u_if.hold = 1'b0;
        step();
        check("t5_wdata_a", u_if.write_data, 32'hA);
        check("t5_busy_a", 32'(u_if.busy1), 32'd1);
        step();
        check("t5_wdata_b", u_if.write_data, 32'hB);
        check("t5_busy_b", 32'(u_if.busy1), 32'd1);
        step();
        check("t5_busy_done", 32'(u_if.busy1), 32'd0);
        check("t5_bank7", bank[7], 32'hB);

        // Asynchronous reset in the middle of a drain.
        u_if.chk_addr1 = 5'd9;
        u_if.hold = 1'b1;
        for (int i = 8; i <= 11; i++) push_alu(5'(i), 32'(i));
        u_if.hold = 1'b0;
        step();
        check("t6_pw_pre", 32'(u_if.pw), 32'd1);
        check("t6_count_pre", 32'(u_if.count), 32'd3);
        check("t6_busy_pre", 32'(u_if.busy1), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_pw_rst", 32'(u_if.pw), 32'd0);
        check("t6_waddr_rst", 32'(u_if.write_addr), 32'd0);
        check("t6_wdata_rst", u_if.write_data, 32'd0);
        check("t6_count_rst", 32'(u_if.count), 32'd0);
        check("t6_busy_rst", 32'(u_if.busy1), 32'd0);
        snap = wr_cnt;
        step();
        step();
        reset = 1'b1;
        repeat (5) step();
        check("t6_no_writes", 32'(wr_cnt - snap), 32'd0);
        check("t6_pw_after", 32'(u_if.pw), 32'd0);
        check("t6_count_after", 32'(u_if.count), 32'd0);
        check("t6_bank8", bank[8], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
